// File: rtl/vga_sync.sv
// VGA raster timing generator: pixel divider, h/v counters, registered
// visible/sync/frame decodes and delayed sync copies for the RGB pipeline.
module vga_sync #(
   parameter int unsigned H_DISPLAY  = 640,
   parameter int unsigned H_FRONT    = 16,
   parameter int unsigned H_SYNC     = 96,
   parameter int unsigned H_BACK     = 48,
   parameter int unsigned V_DISPLAY  = 480,
   parameter int unsigned V_FRONT    = 10,
   parameter int unsigned V_SYNC     = 2,
   parameter int unsigned V_BACK     = 33,
   parameter int unsigned SYNC_POL   = 0,
   parameter int unsigned CLK_DIV    = 1,
   parameter int unsigned SYNC_DELAY = 1
) (
   input  logic       i_clk_d,
   input  logic       i_rst_n,
   output logic [9:0] o_pixel_x,
   output logic [9:0] o_pixel_y,
   output logic       o_video_on,
   output logic       o_hsync,
   output logic       o_vsync,
   output logic       o_hsync_d,
   output logic       o_vsync_d,
   output logic       o_frame_start
);

   localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

   localparam logic [9:0] H_MAX    = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_MAX    = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
   localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
   localparam logic [9:0] HS_FIRST = 10'(H_DISPLAY + H_FRONT);
   localparam logic [9:0] HS_LAST  = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
   localparam logic [9:0] VS_FIRST = 10'(V_DISPLAY + V_FRONT);
   localparam logic [9:0] VS_LAST  = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);
   localparam logic [3:0] DIV_MAX  = 4'(CLK_DIV - 1);
   localparam logic       ACT      = (SYNC_POL != 0);

   logic [3:0] r_div;
   logic [9:0] r_x;
   logic [9:0] r_y;
   logic       r_video;
   logic       r_hsync;
   logic       r_vsync;
   logic       r_frame;

   logic       w_tick;
   logic       w_h_wrap;
   logic [3:0] w_div_next;
   logic [9:0] w_x_next;
   logic [9:0] w_y_next;
   logic       w_video_next;
   logic       w_hsync_next;
   logic       w_vsync_next;
   logic       w_frame_next;

   // Next counter state and decodes of it, so registered flags line up with the counters
   always_comb begin
      w_tick       = (r_div == DIV_MAX);
      w_div_next   = w_tick ? 4'd0 : r_div + 4'd1;
      w_h_wrap     = w_tick && (r_x == H_MAX);
      w_x_next     = r_x;
      w_y_next     = r_y;
      if (w_tick) begin
         w_x_next = (r_x == H_MAX) ? 10'd0 : r_x + 10'd1;
      end
      if (w_h_wrap) begin
         w_y_next = (r_y == V_MAX) ? 10'd0 : r_y + 10'd1;
      end
      w_frame_next = w_h_wrap && (r_y == V_MAX);
      w_video_next = (w_x_next < H_VIS) && (w_y_next < V_VIS);
      w_hsync_next = ((w_x_next >= HS_FIRST) && (w_x_next <= HS_LAST)) ? ACT : ~ACT;
      w_vsync_next = ((w_y_next >= VS_FIRST) && (w_y_next <= VS_LAST)) ? ACT : ~ACT;
   end

   // Counter and flag registers
   always_ff @(posedge i_clk_d or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_div   <= 4'd0;
         r_x     <= 10'd0;
         r_y     <= 10'd0;
         r_video <= 1'b0;
         r_hsync <= ~ACT;
         r_vsync <= ~ACT;
         r_frame <= 1'b0;
      end else begin
         r_div   <= w_div_next;
         r_x     <= w_x_next;
         r_y     <= w_y_next;
         r_video <= w_video_next;
         r_hsync <= w_hsync_next;
         r_vsync <= w_vsync_next;
         r_frame <= w_frame_next;
      end
   end

   generate
      if (SYNC_DELAY == 0) begin : g_no_delay
         assign o_hsync_d = r_hsync;
         assign o_vsync_d = r_vsync;
      end else begin : g_delay
         logic [SYNC_DELAY-1:0] r_hs_dly;
         logic [SYNC_DELAY-1:0] r_vs_dly;

         // Sync delay line, advanced on every clock regardless of pixel tick
         always_ff @(posedge i_clk_d or negedge i_rst_n) begin
            if (!i_rst_n) begin
               r_hs_dly <= {SYNC_DELAY{~ACT}};
               r_vs_dly <= {SYNC_DELAY{~ACT}};
            end else begin
               r_hs_dly[0] <= r_hsync;
               r_vs_dly[0] <= r_vsync;
               for (int i = 1; i < int'(SYNC_DELAY); i++) begin
                  r_hs_dly[i] <= r_hs_dly[i-1];
                  r_vs_dly[i] <= r_vs_dly[i-1];
               end
            end
         end

         assign o_hsync_d = r_hs_dly[SYNC_DELAY-1];
         assign o_vsync_d = r_vs_dly[SYNC_DELAY-1];
      end
   endgenerate

   assign o_pixel_x     = r_x;
   assign o_pixel_y     = r_y;
   assign o_video_on    = r_video;
   assign o_hsync       = r_hsync;
   assign o_vsync       = r_vsync;
   assign o_frame_start = r_frame;

endmodule

// File: tb/tb_vga_sync.sv
// Bench for vga_sync: one default-timing instance plus two shrunken-timing
// instances, checked each cycle against an arithmetic raster model.
module tb_vga_sync;

   typedef struct {
      int hd, hf, hs, hb, vd, vf, vs, vb;
      bit pol;
      int div, dly;
   } cfg_t;

   typedef struct packed {
      logic [9:0] x;
      logic [9:0] y;
      logic       vid;
      logic       hs;
      logic       vs;
      logic       hsd;
      logic       vsd;
      logic       fs;
   } obs_t;

   typedef struct {
      longint k;
      int     x, y;
      bit     vid, hs, hsd, fs;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [9:0] x0, y0, x1, y1, x2, y2;
   logic vid0, hs0, vs0, hsd0, vsd0, fs0;
   logic vid1, hs1, vs1, hsd1, vsd1, fs1;
   logic vid2, hs2, vs2, hsd2, vsd2, fs2;

   vga_sync u0 (
      .i_clk_d(clk), .i_rst_n(rst_n), .o_pixel_x(x0), .o_pixel_y(y0), .o_video_on(vid0),
      .o_hsync(hs0), .o_vsync(vs0), .o_hsync_d(hsd0), .o_vsync_d(vsd0), .o_frame_start(fs0)
   );

   vga_sync #(
      .H_DISPLAY(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(3),
      .V_DISPLAY(10), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
      .SYNC_POL(1), .CLK_DIV(3), .SYNC_DELAY(3)
   ) u1 (
      .i_clk_d(clk), .i_rst_n(rst_n), .o_pixel_x(x1), .o_pixel_y(y1), .o_video_on(vid1),
      .o_hsync(hs1), .o_vsync(vs1), .o_hsync_d(hsd1), .o_vsync_d(vsd1), .o_frame_start(fs1)
   );

   vga_sync #(
      .H_DISPLAY(8), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
      .V_DISPLAY(5), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
      .SYNC_POL(0), .CLK_DIV(4), .SYNC_DELAY(0)
   ) u2 (
      .i_clk_d(clk), .i_rst_n(rst_n), .o_pixel_x(x2), .o_pixel_y(y2), .o_video_on(vid2),
      .o_hsync(hs2), .o_vsync(vs2), .o_hsync_d(hsd2), .o_vsync_d(vsd2), .o_frame_start(fs2)
   );

   obs_t o0, o1, o2;
   assign o0 = {x0, y0, vid0, hs0, vs0, hsd0, vsd0, fs0};
   assign o1 = {x1, y1, vid1, hs1, vs1, hsd1, vsd1, fs1};
   assign o2 = {x2, y2, vid2, hs2, vs2, hsd2, vsd2, fs2};

   cfg_t   cfg [3];
   longint k;           // clock edges seen since the last reset release
   int     n_vec = 0;
   int     n_bad = 0;

   // Sync level after j edges; j <= 0 means still holding the reset value
   function automatic bit sync_lvl(input cfg_t c, input longint j, input bit vert);
      longint ht, vt, p, pos, lo, w;
      if (j <= 0) return ~c.pol;
      ht = c.hd + c.hf + c.hs + c.hb;
      vt = c.vd + c.vf + c.vs + c.vb;
      p  = j / c.div;
      if (vert) begin
         pos = (p / ht) % vt; lo = c.vd + c.vf; w = c.vs;
      end else begin
         pos = p % ht;        lo = c.hd + c.hf; w = c.hs;
      end
      return (pos >= lo && pos < lo + w) ? c.pol : ~c.pol;
   endfunction

   function automatic obs_t model(input cfg_t c, input longint kk);
      obs_t   e;
      longint ht, vt, p;
      ht    = c.hd + c.hf + c.hs + c.hb;
      vt    = c.vd + c.vf + c.vs + c.vb;
      p     = kk / c.div;
      e.x   = 10'(p % ht);
      e.y   = 10'((p / ht) % vt);
      e.vid = (kk > 0) && (p % ht < c.hd) && ((p / ht) % vt < c.vd);
      e.hs  = sync_lvl(c, kk, 1'b0);
      e.vs  = sync_lvl(c, kk, 1'b1);
      e.hsd = sync_lvl(c, kk - c.dly, 1'b0);
      e.vsd = sync_lvl(c, kk - c.dly, 1'b1);
      e.fs  = (kk > 0) && (kk % c.div == 0) && (p % (ht * vt) == 0);
      return e;
   endfunction

   function automatic obs_t get_obs(input int id);
      case (id)
         0:       return o0;
         1:       return o1;
         default: return o2;
      endcase
   endfunction

   task automatic check_all(input string tag);
      obs_t a, e;
      for (int i = 0; i < 3; i++) begin
         a = get_obs(i);
         e = model(cfg[i], k);
         n_vec++;
         if (a !== e) begin
            n_bad++;
            $display("FAIL %s u%0d k=%0d: got x=%0d y=%0d vid=%b hs=%b vs=%b hsd=%b vsd=%b fs=%b, want x=%0d y=%0d vid=%b hs=%b vs=%b hsd=%b vsd=%b fs=%b",
                     tag, i, k, a.x, a.y, a.vid, a.hs, a.vs, a.hsd, a.vsd, a.fs,
                     e.x, e.y, e.vid, e.hs, e.vs, e.hsd, e.vsd, e.fs);
         end
      end
   endtask

   task automatic run_cycles(input int n);
      repeat (n) begin
         @(posedge clk);
         k++;
         @(negedge clk);
         check_all("run");
      end
   endtask

   // Assert reset between clock edges and confirm outputs drop without an edge
   task automatic async_reset(input int hold);
      @(posedge clk);
      k++;
      #2;
      rst_n = 1'b0;
      #1;
      k = 0;
      check_all("async_rst");
      repeat (hold) begin
         @(negedge clk);
         check_all("rst_hold");
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   vec_t tbl [12];
   int   cnt_a, cnt_b, cnt_c;

   initial begin
      cfg[0] = '{hd:640, hf:16, hs:96, hb:48, vd:480, vf:10, vs:2, vb:33, pol:1'b0, div:1, dly:1};
      cfg[1] = '{hd:16, hf:2, hs:4, hb:3, vd:10, vf:2, vs:2, vb:3, pol:1'b1, div:3, dly:3};
      cfg[2] = '{hd:8, hf:1, hs:2, hb:1, vd:5, vf:1, vs:1, vb:1, pol:1'b0, div:4, dly:0};

      // Hand-derived boundary points for the default instance
      tbl[0]  = '{k:1,   x:1,   y:0, vid:1, hs:1, hsd:1, fs:0};
      tbl[1]  = '{k:639, x:639, y:0, vid:1, hs:1, hsd:1, fs:0};
      tbl[2]  = '{k:640, x:640, y:0, vid:0, hs:1, hsd:1, fs:0};
      tbl[3]  = '{k:655, x:655, y:0, vid:0, hs:1, hsd:1, fs:0};
      tbl[4]  = '{k:656, x:656, y:0, vid:0, hs:0, hsd:1, fs:0};
      tbl[5]  = '{k:657, x:657, y:0, vid:0, hs:0, hsd:0, fs:0};
      tbl[6]  = '{k:751, x:751, y:0, vid:0, hs:0, hsd:0, fs:0};
      tbl[7]  = '{k:752, x:752, y:0, vid:0, hs:1, hsd:0, fs:0};
      tbl[8]  = '{k:753, x:753, y:0, vid:0, hs:1, hsd:1, fs:0};
      tbl[9]  = '{k:799, x:799, y:0, vid:0, hs:1, hsd:1, fs:0};
      tbl[10] = '{k:800, x:0,   y:1, vid:1, hs:1, hsd:1, fs:0};
      tbl[11] = '{k:801, x:1,   y:1, vid:1, hs:1, hsd:1, fs:0};

      k = 0;
      rst_n = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check_all("reset");
         n_vec++;
         if (!(x0 === 10'd0 && y0 === 10'd0 && vid0 === 1'b0 && hs0 === 1'b1 &&
               vs0 === 1'b1 && hsd0 === 1'b1 && vsd0 === 1'b1 && fs0 === 1'b0)) begin
            n_bad++;
            $display("FAIL reset_const: got x=%0d y=%0d vid=%b hs=%b vs=%b hsd=%b vsd=%b fs=%b, want 0 0 0 1 1 1 1 0",
                     x0, y0, vid0, hs0, vs0, hsd0, vsd0, fs0);
         end
      end
      rst_n = 1'b1;

      for (int i = 0; i < 12; i++) begin
         run_cycles(int'(tbl[i].k - k));
         n_vec++;
         if (!(x0 === 10'(tbl[i].x) && y0 === 10'(tbl[i].y) && vid0 === tbl[i].vid &&
               hs0 === tbl[i].hs && hsd0 === tbl[i].hsd && fs0 === tbl[i].fs)) begin
            n_bad++;
            $display("FAIL table[%0d] k=%0d: got x=%0d y=%0d vid=%b hs=%b hsd=%b fs=%b, want x=%0d y=%0d vid=%b hs=%b hsd=%b fs=%b",
                     i, tbl[i].k, x0, y0, vid0, hs0, hsd0, fs0, tbl[i].x, tbl[i].y,
                     tbl[i].vid, tbl[i].hs, tbl[i].hsd, tbl[i].fs);
         end
      end

      // Random run lengths with mid-frame asynchronous resets
      for (int s = 0; s < 8; s++) begin
         run_cycles(int'($urandom_range(20, 2500)));
         async_reset(int'($urandom_range(0, 3)));
      end

      // Aggregate counts over whole frames of the small instances
      async_reset(1);
      cnt_a = 0; cnt_b = 0; cnt_c = 0;
      for (int c = 1; c <= 1275; c++) begin
         run_cycles(1);
         if (hs1 === 1'b1) cnt_a++;
      end
      n_vec++;
      if (cnt_a != 204) begin
         n_bad++;
         $display("FAIL u1_hsync_active_cycles: got %0d, want 204", cnt_a);
      end

      async_reset(0);
      for (int c = 1; c <= 1152; c++) begin
         run_cycles(1);
         if (fs2 === 1'b1) cnt_b++;
         if (c <= 384 && vid2 === 1'b1) cnt_c++;
      end
      n_vec++;
      if (cnt_b != 3) begin
         n_bad++;
         $display("FAIL u2_frame_start_count: got %0d, want 3", cnt_b);
      end
      n_vec++;
      if (cnt_c != 160) begin
         n_bad++;
         $display("FAIL u2_video_on_cycles: got %0d, want 160", cnt_c);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/vga_sync.md
Name: vga_sync

Overview:
- VGA timing generator for the display path; drives the pixel generator that paints the maze walls, borders and aeroplane.
- Produces the raster coordinates, the visible-area flag and the horizontal/vertical sync pulses from the shared pixel clock.
- Also provides copies of the sync signals delayed to line up with the pixel generator's registered RGB, plus a start-of-frame strobe for game-state updates such as aeroplane motion.

Parameters:
- H_DISPLAY, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_DISPLAY, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- SYNC_POL, 0, active level of hsync/vsync (0 = active-low)
- CLK_DIV, 1, clk_d cycles per pixel (1..16)
- SYNC_DELAY, 1, clk_d cycles of delay from hsync/vsync to hsync_d/vsync_d (0..4)

Ports:
- clk_d  in  1  pixel clock shared with the pixel generator
- rst_n  in  1  reset, asynchronous assert, active-low
- pixel_x  out  10  horizontal counter, 0..H_TOTAL-1
- pixel_y  out  10  vertical counter, 0..V_TOTAL-1
- video_on  out  1  high while pixel_x < H_DISPLAY and pixel_y < V_DISPLAY
- hsync  out  1  horizontal sync, aligned with pixel_x
- vsync  out  1  vertical sync, aligned with pixel_y
- hsync_d  out  1  hsync delayed SYNC_DELAY clk_d cycles
- vsync_d  out  1  vsync delayed SYNC_DELAY clk_d cycles
- frame_start  out  1  one-clk_d pulse when the counters wrap to (0,0)

Behaviour:
- Totals: H_TOTAL = sum of the H_* parameters (800); V_TOTAL = sum of the V_* parameters (525).
- Pixel tick:
  - Divider counts 0..CLK_DIV-1; pix_tick is high when divider = CLK_DIV-1.
  - CLK_DIV=1 gives pix_tick on every cycle.
- Horizontal counter: on pix_tick, h increments; at H_TOTAL-1 it wraps to 0.
- Vertical counter:
  - v increments only on the tick where h wraps.
  - At V_TOTAL-1 with h wrapping, v wraps to 0.
- Output registers:
  - pixel_x/pixel_y are the counter registers themselves.
  - video_on, hsync, vsync and frame_start are registered decodes of the next counter value, so they are valid in the same cycle as the matching pixel_x/pixel_y. There is no skew between coordinates and flags.
- hsync is active when H_DISPLAY+H_FRONT <= pixel_x <= H_DISPLAY+H_FRONT+H_SYNC-1 (656..751). Otherwise it is at the inactive level, ~SYNC_POL.
- vsync is active when V_DISPLAY+V_FRONT <= pixel_y <= V_DISPLAY+V_FRONT+V_SYNC-1 (490..491).
- frame_start:
  - High for exactly one clk_d cycle, on the cycle the counters first show (0,0) after wrapping from (H_TOTAL-1, V_TOTAL-1).
  - Not asserted for the initial (0,0) after reset.
- hsync_d/vsync_d:
  - Produced by a SYNC_DELAY-deep shift register clocked on every clk_d.
  - SYNC_DELAY=0 means a direct copy.
  - Default 1 matches the one-cycle RGB register in the pixel generator.
- Reset (rst_n low, asynchronous), all values held while low:
  - divider, pixel_x, pixel_y: 0
  - video_on: 0
  - frame_start: 0
  - hsync, vsync and all delay stages: ~SYNC_POL
- Release:
  - The first clk_d edge after rst_n rises updates video_on to the decode of the counter state.
  - With CLK_DIV=1, pixel_x becomes 1 and video_on becomes 1 on that edge.
- Reset mid-frame: counters return to (0,0) immediately; no partial frame_start pulse is emitted.
- Counters never exceed their totals; no other wrap values are legal.

Test Plan:
- Reset then release, defaults → during reset pixel_x=0, pixel_y=0, video_on=0, hsync=vsync=hsync_d=vsync_d=1. First edge after release: pixel_x=1, video_on=1.
- Run one line at defaults → pixel_x wraps 799→0 every 800 cycles and pixel_y increments at the wrap. hsync is low exactly for pixel_x 656..751 (96 cycles); hsync_d is the same waveform one cycle later.
- Run two full frames → frame period 420000 cycles, with frame_start high once per frame at (0,0). video_on is high for 307200 cycles per frame. vsync is low for 1600 consecutive cycles at pixel_y 490..491.
- CLK_DIV=4 → each pixel_x value is held 4 cycles, line length is 3200 cycles, hsync low for 384 cycles.
- Assert rst_n at pixel_x=300, pixel_y=200 → outputs go to reset values without waiting for a clock edge. After release, counting restarts from (0,0) and the first frame_start appears 420000 cycles later.
- SYNC_POL=1, SYNC_DELAY=3 → hsync is high for pixel_x 656..751 and idle low; hsync_d lags hsync by exactly 3 cycles.
